// File: rtl/ser_di_shifter.sv
// ser_di_shifter: turns toggle-triggered register writes into 3-wire serial writes (clk, data, per-lane le_n).
// Optional ser_miso readback into rd_data is enabled by defining SER_DI_READBACK_EN.
module ser_di_shifter #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 24,
    parameter int N_LANES   = 4
) (
    input  logic               user_clk,
    input  logic               user_rst,
    input  logic [31:0]        user_data_in,
    output logic               ser_clk,
    output logic               ser_data,
    output logic [N_LANES-1:0] ser_le_n,
    output logic               busy,
    output logic [15:0]        done_cnt,
    output logic               err_nosel,
    output logic [23:0]        rd_data,
    input  logic               ser_miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD} state_t;

    localparam logic [8:0] DIV_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);

    state_t             state, state_nxt;
    logic [31:0]        cmd_q;
    logic               last_tog, armed;
    logic [8:0]         div_cnt;
    logic [4:0]         bit_cnt;
    logic [23:0]        shreg, sh_next;
    logic [N_LANES-1:0] sel;
    logic               pending, div_end, launch, nosel;
    logic               unused_bits;

    // Left unreset so the word held through reset is already visible when arming.
    always_ff @(posedge user_clk) begin
        cmd_q <= user_data_in;
    end

    assign sel         = cmd_q[N_LANES+23:24];
    assign pending     = armed && (cmd_q[31] != last_tog);
    assign sh_next     = shreg << 1;
    assign unused_bits = ^cmd_q[30:24];

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        nosel     = 1'b0;
        div_end   = (state == HOLD) ? (div_cnt == HOLD_LAST) : (div_cnt == DIV_LAST);
        case (state)
            IDLE: begin
                if (pending) begin
                    if (sel == '0) begin
                        nosel = 1'b1;
                    end else begin
                        launch    = 1'b1;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP:    if (div_end) state_nxt = SHIFT_HI;
            SHIFT_HI: if (div_end) state_nxt = (bit_cnt == 5'd1) ? HOLD : SHIFT_LO;
            SHIFT_LO: if (div_end) state_nxt = SHIFT_HI;
            HOLD:     if (div_end) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            armed     <= 1'b0;
            last_tog  <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
            ser_le_n  <= '1;
            busy      <= 1'b0;
            done_cnt  <= '0;
            err_nosel <= 1'b0;
        end else begin
            if (state == IDLE || div_end) div_cnt <= '0;
            else                          div_cnt <= div_cnt + 9'd1;

            // Arming cycle adopts the current toggle level so a stale bit 31 never fires.
            if (!armed) begin
                armed    <= 1'b1;
                last_tog <= cmd_q[31];
            end else if (state == IDLE && pending) begin
                last_tog <= cmd_q[31];
            end

            if (nosel) err_nosel <= 1'b1;

            if (launch) begin
                shreg    <= cmd_q[23:0];
                ser_data <= cmd_q[DATA_BITS-1];
                ser_le_n <= ~sel;
                bit_cnt  <= 5'(DATA_BITS);
                busy     <= 1'b1;
            end

            case (state)
                SETUP:    if (div_end) ser_clk <= 1'b1;
                SHIFT_HI: begin
                    if (div_end) begin
                        ser_clk <= 1'b0;
                        bit_cnt <= bit_cnt - 5'd1;
                        if (bit_cnt == 5'd1) begin
                            ser_le_n <= '1;
                        end else begin
                            shreg    <= sh_next;
                            ser_data <= sh_next[DATA_BITS-1];
                        end
                    end
                end
                SHIFT_LO: if (div_end) ser_clk <= 1'b1;
                HOLD: begin
                    if (div_end) begin
                        busy     <= 1'b0;
                        done_cnt <= done_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SER_DI_READBACK_EN
    localparam logic [23:0] DMASK = 24'((32'd1 << DATA_BITS) - 32'd1);
    logic [23:0] rx;

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            rx      <= '0;
            rd_data <= '0;
        end else begin
            if (state_nxt == SHIFT_HI && state != SHIFT_HI) rx <= {rx[22:0], ser_miso};
            if (state_nxt == HOLD && state != HOLD)         rd_data <= rx & DMASK;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = ser_miso;
    assign rd_data     = '0;
`endif
endmodule

// File: tb/tb_ser_di_shifter.sv
// Directed bench for ser_di_shifter: table of commands plus hand-written multi-cycle sequences.
module tb_ser_di_shifter;
    logic        user_clk = 1'b0;
    logic        user_rst;
    logic [31:0] user_data_in;
    logic        ser_clk, ser_data, busy, err_nosel;
    logic [3:0]  ser_le_n;
    logic [15:0] done_cnt;
    logic [23:0] rd_data;
    logic        ser_miso;

    logic [23:0] miso_pat = 24'h5A5A5A;
    int          miso_idx = 0;
    int          checks = 0;
    int          errors = 0;

    ser_di_shifter dut (
        .user_clk(user_clk), .user_rst(user_rst), .user_data_in(user_data_in),
        .ser_clk(ser_clk), .ser_data(ser_data), .ser_le_n(ser_le_n), .busy(busy),
        .done_cnt(done_cnt), .err_nosel(err_nosel), .rd_data(rd_data), .ser_miso(ser_miso)
    );

    always #5 user_clk = ~user_clk;

    // Next miso bit is presented after every ser_clk rise, ahead of the following rise.
    assign ser_miso = (miso_idx < 24) ? miso_pat[23 - miso_idx] : 1'b0;
    always @(posedge ser_clk) miso_idx = miso_idx + 1;

    typedef struct {
        logic [31:0] word;
        logic        launch;
        logic [23:0] bits;
        logic [3:0]  le_n;
        logic [15:0] done;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string name);
        logic found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(posedge user_clk); #1;
            if (busy === lvl) found = 1'b1;
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          first_busy = -1;
        int          busy_len = 0, rises = 0, le_bad = 0, dat_bad = 0;
        logic [23:0] cap = '0;
        logic        pclk, pdat;
        logic        ended = 1'b0;
        pclk = ser_clk;
        pdat = ser_data;
        user_data_in = v.word;
        for (int i = 1; i <= 260 && !ended; i++) begin
            @(posedge user_clk); #1;
            if (busy) begin
                busy_len++;
                if (first_busy < 0) first_busy = i;
            end else if (first_busy >= 0) begin
                ended = 1'b1;
            end
            if (ser_clk && !pclk) begin
                rises++;
                cap = {cap[22:0], ser_data};
                if (ser_le_n !== v.le_n) le_bad++;
            end
            if (ser_clk && pclk && ser_data !== pdat) dat_bad++;
            pclk = ser_clk;
            pdat = ser_data;
        end
        if (v.launch) begin
            check($sformatf("v%0d_ended", idx), {31'd0, ended}, 32'd1);
            check($sformatf("v%0d_latency", idx), first_busy, 32'd2);
            check($sformatf("v%0d_busy_len", idx), busy_len, 32'd200);
            check($sformatf("v%0d_rises", idx), rises, 32'd24);
            check($sformatf("v%0d_bits", idx), {8'd0, cap}, {8'd0, v.bits});
            check($sformatf("v%0d_le_bad", idx), le_bad, 32'd0);
            check($sformatf("v%0d_data_hi_stable", idx), dat_bad, 32'd0);
        end else begin
            check($sformatf("v%0d_no_busy", idx), busy_len, 32'd0);
            check($sformatf("v%0d_no_clk", idx), rises, 32'd0);
        end
        check($sformatf("v%0d_done", idx), {16'd0, done_cnt}, {16'd0, v.done});
        check($sformatf("v%0d_err", idx), {31'd0, err_nosel}, {31'd0, v.err});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad_busy, bad_le, seen;
        vec_t rb;

        vecs[0] = '{32'h81ABCDEF, 1'b1, 24'hABCDEF, 4'b1110, 16'd1, 1'b0};
        vecs[1] = '{32'h05123456, 1'b1, 24'h123456, 4'b1010, 16'd2, 1'b0};
        vecs[2] = '{32'h80000055, 1'b0, 24'h000000, 4'b1111, 16'd2, 1'b1};
        vecs[3] = '{32'h0F000001, 1'b1, 24'h000001, 4'b0000, 16'd3, 1'b1};
        vecs[4] = '{32'h08FEDCBA, 1'b0, 24'h000000, 4'b1111, 16'd3, 1'b1};
        vecs[5] = '{32'h88FEDCBA, 1'b1, 24'hFEDCBA, 4'b0111, 16'd4, 1'b1};
        vecs[6] = '{32'h00FFFFFF, 1'b0, 24'h000000, 4'b1111, 16'd4, 1'b1};
        vecs[7] = '{32'hF2555555, 1'b1, 24'h555555, 4'b1101, 16'd5, 1'b1};

        // Reset with a stale toggle word held across release.
        user_rst = 1'b1;
        user_data_in = 32'h8F123456;
        repeat (3) @(posedge user_clk);
        #1;
        check("rst_ser_clk", {31'd0, ser_clk}, 32'd0);
        check("rst_ser_data", {31'd0, ser_data}, 32'd0);
        check("rst_le_n", {28'd0, ser_le_n}, 32'hF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {16'd0, done_cnt}, 32'd0);
        check("rst_err", {31'd0, err_nosel}, 32'd0);
        check("rst_rd_data", {8'd0, rd_data}, 32'd0);
        user_rst = 1'b0;
        bad_busy = 0;
        bad_le = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge user_clk); #1;
            if (busy !== 1'b0) bad_busy++;
            if (ser_le_n !== 4'hF) bad_le++;
        end
        check("stale_no_busy", bad_busy, 32'd0);
        check("stale_le_idle", bad_le, 32'd0);

        // Re-reset with bit 31 low so the table starts from a known toggle level.
        user_rst = 1'b1;
        user_data_in = 32'h01ABCDEF;
        repeat (3) @(posedge user_clk);
        #1;
        user_rst = 1'b0;
        repeat (5) @(posedge user_clk);
        #1;
        check("rearm_no_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Two toggles during a transfer collapse into nothing.
        user_data_in = 32'h01000003;
        wait_busy(1'b1, 5, "dbl_start");
        repeat (50) @(posedge user_clk);
        #1;
        user_data_in = 32'h81000003;
        repeat (30) @(posedge user_clk);
        #1;
        user_data_in = 32'h01000003;
        wait_busy(1'b0, 300, "dbl_end");
        seen = 0;
        for (int i = 0; i < 220; i++) begin
            @(posedge user_clk); #1;
            if (busy) seen++;
        end
        check("dbl_no_second", seen, 32'd0);
        check("dbl_done", {16'd0, done_cnt}, 32'd6);

        // One toggle during a transfer relaunches right after IDLE with the new word.
        user_data_in = 32'h83000007;
        wait_busy(1'b1, 5, "sgl_start");
        repeat (50) @(posedge user_clk);
        #1;
        user_data_in = 32'h03000009;
        wait_busy(1'b0, 300, "sgl_first_end");
        @(posedge user_clk); #1;
        check("sgl_relaunch", {31'd0, busy}, 32'd1);
        check("sgl_relaunch_le", {28'd0, ser_le_n}, 32'hC);
        wait_busy(1'b0, 300, "sgl_second_end");
        check("sgl_done", {16'd0, done_cnt}, 32'd8);

        // Readback of ser_miso pattern.
        miso_idx = 0;
        rb = '{32'h81000000, 1'b1, 24'h000000, 4'b1110, 16'd9, 1'b1};
        run_vec(rb, 8);
`ifdef SER_DI_READBACK_EN
        check("rd_data", {8'd0, rd_data}, 32'h005A5A5A);
`else
        check("rd_data", {8'd0, rd_data}, 32'd0);
`endif

        // Asynchronous reset in the middle of a transfer.
        user_data_in = 32'h01000000;
        wait_busy(1'b1, 5, "mid_start");
        repeat (99) @(posedge user_clk);
        #1;
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        user_rst = 1'b1;
        #1;
        check("mid_rst_le_n", {28'd0, ser_le_n}, 32'hF);
        check("mid_rst_ser_clk", {31'd0, ser_clk}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {16'd0, done_cnt}, 32'd0);
        check("mid_rst_err", {31'd0, err_nosel}, 32'd0);
        repeat (3) @(posedge user_clk);
        #1;
        user_rst = 1'b0;
        repeat (5) @(posedge user_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
